icache_line_collector: RTL and testbench

- Downstream of the icache request generator on the response side.
- Collects the four 128-bit response beats (tranid 0..3) of a single icache miss into one 512-bit line, then issues a one-cycle line write to the icache data/tag arrays.
- After the write it pulses ack, which releases the request generator from its wait-for-ack state.
- Filters responses by core/channel and aborts on a snoop hit to the line being filled, a restart, or a timeout.

---
 rtl/icache_line_collector.sv | 120 ++++++++++++
 tb/tb_icache_line_collector.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_line_collector.sv
// rtl/icache_line_collector.sv - gathers four icache response beats into one line write, then acks
// Aborts on snoop hit, restart or timeout; all outputs registered.
module icache_line_collector #(
   parameter logic [5:0] CORENO  = 6'd1,
   parameter logic [2:0] CID     = 3'd0,
   parameter int         ADR_W   = 32,
   parameter int         IDX_HI  = 13,
   parameter logic [7:0] TIMEOUT = 8'd255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [ADR_W-1:0] miss_adr,
   input  logic             resp_v,
   input  logic [5:0]       resp_core,
   input  logic [2:0]       resp_channel,
   input  logic [3:0]       resp_tranid,
   input  logic [127:0]     resp_dat,
   input  logic             resp_err,
   input  logic             snoop_v,
   input  logic [ADR_W-1:0] snoop_adr,
   input  logic [2:0]       snoop_cid,
   output logic             line_wr,
   output logic [ADR_W-1:0] line_adr,
   output logic [511:0]     line_dat,
   output logic             line_err,
   output logic             ack,
   output logic             busy,
   output logic             timeout
);

   typedef enum logic [1:0] {IDLE, COLLECT, WRITE, ACK} state_t;

   state_t     state;
   logic [3:0] mask;
   logic [7:0] timer;
   logic       err_acc;

   logic       accept;
   logic       snoop_hit;
   logic [3:0] beat_bit;
   logic [3:0] mask_nxt;
   logic       unused_bits;

   assign unused_bits = ^{miss_adr[5:0], snoop_adr[5:0], snoop_adr[ADR_W-1:IDX_HI+1]};

   always_comb begin
      accept    = (state == COLLECT) && resp_v && (resp_core == CORENO) &&
                  (resp_channel == CID) && (resp_tranid < 4'd4);
      beat_bit  = accept ? (4'b0001 << resp_tranid[1:0]) : 4'b0000;
      mask_nxt  = mask | beat_bit;
      snoop_hit = snoop_v && (snoop_adr[IDX_HI:6] == line_adr[IDX_HI:6]) &&
                  (snoop_cid != CID) && ((state == COLLECT) || (state == WRITE));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         mask     <= 4'b0000;
         timer    <= 8'd0;
         err_acc  <= 1'b0;
         line_wr  <= 1'b0;
         line_adr <= '0;
         line_dat <= '0;
         line_err <= 1'b0;
         ack      <= 1'b0;
         busy     <= 1'b0;
         timeout  <= 1'b0;
      end else begin
         line_wr <= 1'b0;
         ack     <= 1'b0;
         timeout <= 1'b0;
         // Abort and restart outrank everything, so a beat in the same cycle is dropped.
         if (snoop_hit) begin
            state <= IDLE;
            mask  <= 4'b0000;
            busy  <= 1'b0;
         end else if (start) begin
            line_adr <= {miss_adr[ADR_W-1:6], 6'b000000};
            mask     <= 4'b0000;
            err_acc  <= 1'b0;
            timer    <= 8'd0;
            state    <= COLLECT;
            busy     <= 1'b1;
         end else begin
            case (state)
               COLLECT: begin
                  if (accept) begin
                     line_dat[{resp_tranid[1:0], 7'b0000000} +: 128] <= resp_dat;
                     err_acc <= err_acc | resp_err;
                  end
                  mask <= mask_nxt;
                  if (timer != TIMEOUT)
                     timer <= timer + 8'd1;
                  if (mask_nxt == 4'hF) begin
                     state    <= WRITE;
                     line_wr  <= 1'b1;
                     line_err <= err_acc | (accept & resp_err);
                  end else if (timer == TIMEOUT) begin
                     state   <= IDLE;
                     timeout <= 1'b1;
                     busy    <= 1'b0;
                  end
               end
               WRITE: begin
                  state <= ACK;
                  ack   <= 1'b1;
               end
               ACK: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_icache_line_collector.sv
// tb/tb_icache_line_collector.sv - table-driven bench for icache_line_collector
// Flags are compared as {line_wr, ack, busy, timeout} after every clock edge.
module tb_icache_line_collector;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [31:0]  miss_adr;
   logic         resp_v;
   logic [5:0]   resp_core;
   logic [2:0]   resp_channel;
   logic [3:0]   resp_tranid;
   logic [127:0] resp_dat;
   logic         resp_err;
   logic         snoop_v;
   logic [31:0]  snoop_adr;
   logic [2:0]   snoop_cid;
   logic         line_wr;
   logic [31:0]  line_adr;
   logic [511:0] line_dat;
   logic         line_err;
   logic         ack;
   logic         busy;
   logic         timeout;

   icache_line_collector dut (
      .clk(clk), .rst(rst), .start(start), .miss_adr(miss_adr),
      .resp_v(resp_v), .resp_core(resp_core), .resp_channel(resp_channel),
      .resp_tranid(resp_tranid), .resp_dat(resp_dat), .resp_err(resp_err),
      .snoop_v(snoop_v), .snoop_adr(snoop_adr), .snoop_cid(snoop_cid),
      .line_wr(line_wr), .line_adr(line_adr), .line_dat(line_dat), .line_err(line_err),
      .ack(ack), .busy(busy), .timeout(timeout)
   );

   always #5 clk = ~clk;

   localparam logic [3:0] I = 4'b0000;
   localparam logic [3:0] C = 4'b0010;
   localparam logic [3:0] W = 4'b1010;
   localparam logic [3:0] A = 4'b0110;

   typedef struct {
      logic         st;
      logic [31:0]  adr;
      logic         rv;
      logic [5:0]   core;
      logic [2:0]   ch;
      logic [3:0]   tid;
      logic [127:0] dat;
      logic         err;
      logic         sv;
      logic [31:0]  sadr;
      logic [2:0]   scid;
      logic [3:0]   exp;
      logic         chk;
      logic [31:0]  eadr;
      logic [511:0] edat;
      logic         eerr;
   } vec_t;

   vec_t vq[$];
   int   checks = 0;
   int   errors = 0;

   task automatic add(input logic st, input logic [31:0] adr, input logic rv, input logic [5:0] core,
                      input logic [2:0] ch, input logic [3:0] tid, input logic [127:0] dat,
                      input logic err, input logic sv, input logic [31:0] sadr,
                      input logic [2:0] scid, input logic [3:0] exp);
      vec_t v;
      v.st = st; v.adr = adr; v.rv = rv; v.core = core; v.ch = ch; v.tid = tid;
      v.dat = dat; v.err = err; v.sv = sv; v.sadr = sadr; v.scid = scid; v.exp = exp;
      v.chk = 1'b0; v.eadr = '0; v.edat = '0; v.eerr = 1'b0;
      vq.push_back(v);
   endtask

   task automatic nop(input logic [3:0] exp);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, exp);
   endtask

   task automatic st(input logic [31:0] adr, input logic [3:0] exp);
      add(1, adr, 0, 0, 0, 0, 0, 0, 0, 0, 0, exp);
   endtask

   task automatic bt(input logic [3:0] tid, input logic [127:0] dat, input logic err, input logic [3:0] exp);
      add(0, 0, 1, 6'd1, 3'd0, tid, dat, err, 0, 0, 0, exp);
   endtask

   task automatic rb(input logic [5:0] core, input logic [2:0] ch, input logic [3:0] tid,
                     input logic [127:0] dat, input logic [3:0] exp);
      add(0, 0, 1, core, ch, tid, dat, 0, 0, 0, 0, exp);
   endtask

   task automatic sn(input logic [31:0] sadr, input logic [2:0] scid, input logic [3:0] exp);
      add(0, 0, 0, 0, 0, 0, 0, 0, 1, sadr, scid, exp);
   endtask

   task automatic want_line(input logic [31:0] adr, input logic [511:0] dat, input logic err);
      vec_t v;
      v = vq.pop_back();
      v.chk = 1'b1; v.eadr = adr; v.edat = dat; v.eerr = err;
      vq.push_back(v);
   endtask

   task automatic idle_inputs();
      start = 0; miss_adr = 0; resp_v = 0; resp_core = 0; resp_channel = 0; resp_tranid = 0;
      resp_dat = 0; resp_err = 0; snoop_v = 0; snoop_adr = 0; snoop_cid = 0;
   endtask

   task automatic beat_now(input logic [3:0] tid, input logic [127:0] dat);
      idle_inputs();
      resp_v = 1; resp_core = 6'd1; resp_channel = 3'd0; resp_tranid = tid; resp_dat = dat;
   endtask

   initial begin
      int  n;
      bit  seen;
      bit  bad;

      idle_inputs();
      rst = 1;
      start = 1;
      miss_adr = 32'hFFFF_FFFF;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({line_wr, ack, busy, timeout, line_err, line_adr, line_dat} !== '0) begin
         errors++;
         $display("FAIL reset flags=%b line_adr=%h line_err=%b want all zero",
                  {line_wr, ack, busy, timeout}, line_adr, line_err);
      end
      rst = 0;
      idle_inputs();

      // In-order fill.
      st(32'h0000_1234, C);
      bt(0, 128'hA0, 0, C); bt(1, 128'hA1, 0, C); bt(2, 128'hA2, 0, C);
      bt(3, 128'hA3, 0, W);
      want_line(32'h0000_1200, {128'hA3, 128'hA2, 128'hA1, 128'hA0}, 0);
      nop(A); nop(I);

      // Filtering: beat in IDLE, wrong core, tranid 4, wrong channel.
      bt(0, 128'hEE, 0, I);
      st(32'h0000_2000, C);
      rb(6'd2, 3'd0, 4'd0, 128'hF0, C);
      rb(6'd1, 3'd0, 4'd4, 128'hF4, C);
      rb(6'd1, 3'd1, 4'd0, 128'hF8, C);
      bt(1, 128'hB1, 0, C); bt(2, 128'hB2, 0, C); bt(3, 128'hB3, 0, C);
      nop(C);
      bt(0, 128'hB0, 0, W);
      want_line(32'h0000_2000, {128'hB3, 128'hB2, 128'hB1, 128'hB0}, 0);
      nop(A); nop(I);

      // Out of order with a duplicate tranid 2.
      st(32'h0000_3000, C);
      bt(2, 128'hC2, 0, C); bt(0, 128'hC0, 0, C); bt(2, 128'hC5, 0, C); bt(3, 128'hC3, 0, C);
      bt(1, 128'hC1, 0, W);
      want_line(32'h0000_3000, {128'hC3, 128'hC5, 128'hC1, 128'hC0}, 0);
      nop(A); nop(I);

      // Error on beat 1.
      st(32'h0000_4000, C);
      bt(0, 128'hD0, 0, C); bt(1, 128'hD1, 1, C); bt(2, 128'hD2, 0, C);
      bt(3, 128'hD3, 0, W);
      want_line(32'h0000_4000, {128'hD3, 128'hD2, 128'hD1, 128'hD0}, 1);
      nop(A); nop(I);

      // Snoop abort from another channel; later beats dropped.
      st(32'h0000_1240, C);
      bt(0, 128'h10, 0, C); bt(1, 128'h11, 0, C);
      sn(32'h0000_1240, 3'd1, I);
      bt(2, 128'h12, 0, I); bt(3, 128'h13, 0, I); nop(I);

      // Own-channel snoop ignored; non-matching index ignored.
      st(32'h0000_1240, C);
      bt(0, 128'h20, 0, C); bt(1, 128'h21, 0, C);
      sn(32'h0000_1240, 3'd0, C);
      sn(32'h0000_1280, 3'd1, C);
      bt(2, 128'h22, 0, C);
      bt(3, 128'h23, 0, W);
      want_line(32'h0000_1240, {128'h23, 128'h22, 128'h21, 128'h20}, 0);
      nop(A); nop(I);

      // Snoop during WRITE suppresses ack.
      st(32'h0000_5000, C);
      bt(0, 128'h30, 0, C); bt(1, 128'h31, 0, C); bt(2, 128'h32, 0, C);
      bt(3, 128'h33, 0, W);
      sn(32'h0000_5000, 3'd2, I);
      nop(I);

      // Restart mid-collect discards earlier beats.
      st(32'h0000_6000, C);
      bt(0, 128'h40, 0, C); bt(1, 128'h41, 1, C);
      st(32'h0000_6040, C);
      bt(2, 128'h52, 0, C); bt(3, 128'h53, 0, C);
      nop(C);
      bt(0, 128'h50, 0, C);
      bt(1, 128'h51, 0, W);
      want_line(32'h0000_6040, {128'h53, 128'h52, 128'h51, 128'h50}, 0);
      nop(A); nop(I);

      for (int i = 0; i < vq.size(); i++) begin
         start = vq[i].st; miss_adr = vq[i].adr; resp_v = vq[i].rv; resp_core = vq[i].core;
         resp_channel = vq[i].ch; resp_tranid = vq[i].tid; resp_dat = vq[i].dat;
         resp_err = vq[i].err; snoop_v = vq[i].sv; snoop_adr = vq[i].sadr; snoop_cid = vq[i].scid;
         @(posedge clk);
         #1;
         checks++;
         if ({line_wr, ack, busy, timeout} !== vq[i].exp) begin
            errors++;
            $display("FAIL row%0d flags got %b want %b", i, {line_wr, ack, busy, timeout}, vq[i].exp);
         end
         if (vq[i].chk) begin
            checks++;
            if (line_adr !== vq[i].eadr || line_dat !== vq[i].edat || line_err !== vq[i].eerr) begin
               errors++;
               $display("FAIL row%0d line adr=%h err=%b dat=%h want adr=%h err=%b dat=%h",
                        i, line_adr, line_err, line_dat, vq[i].eadr, vq[i].eerr, vq[i].edat);
            end
         end
      end

      // Timeout: three beats only, pulse expected 256 edges after entering COLLECT.
      idle_inputs();
      start = 1; miss_adr = 32'h0000_7000;
      @(posedge clk);
      #1;
      for (int b = 0; b < 3; b++) begin
         beat_now(b[3:0], 128'h70 + 128'(b));
         @(posedge clk);
         #1;
      end
      idle_inputs();
      n = 3; seen = 0; bad = 0;
      while (n < 300 && !seen) begin
         @(posedge clk);
         #1;
         n++;
         if (line_wr || ack) bad = 1;
         if (timeout) seen = 1;
      end
      checks++;
      if (!seen || n != 256) begin
         errors++;
         $display("FAIL timeout_latency got seen=%0d edge=%0d want seen=1 edge=256", seen, n);
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL timeout_no_write got line_wr/ack=1 want 0");
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL timeout_busy got %b want 0", busy);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({line_wr, ack, busy, timeout} !== I) begin
         errors++;
         $display("FAIL timeout_after flags got %b want %b", {line_wr, ack, busy, timeout}, I);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
